// File: rtl/rf_pkg.sv
// Shared types and register map for the RF receive path: instruction encoding,
// engine/transaction state enums and the transceiver register addresses.
package rf_pkg;

    localparam int RF_ADDR_W = 10;

    localparam logic [RF_ADDR_W-1:0] INTSTAT_ADDR = 10'h031;
    localparam logic [RF_ADDR_W-1:0] BBREG1_ADDR  = 10'h039;
    localparam logic [RF_ADDR_W-1:0] RX_FIFO_BASE = 10'h300;

    // BBREG1 values: bit 2 holds off the transceiver RX path while we drain the FIFO
    localparam logic [7:0] BBREG1_RX_DIS = 8'h04;
    localparam logic [7:0] BBREG1_RX_EN  = 8'h00;

    typedef enum logic [1:0] {
        RF_SHORT_RD = 2'b00,
        RF_SHORT_WR = 2'b01,
        RF_LONG_RD  = 2'b10,
        RF_LONG_WR  = 2'b11
    } rf_inst_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISR,
        ST_LEN,
        ST_DATA,
        ST_PUSH,
        ST_GAP,
        ST_BB_DIS,
        ST_BB_EN
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SETUP,
        TX_CS,
        TX_BLANK,
        TX_WAIT
    } txn_phase_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rf_spi_txn.sv
// One register transaction towards the RF SPI interface: hold address/inst/wdata
// for SETUP_CYC cycles, pulse cs, ignore ready for 3 cycles, then wait for ready.
module rf_spi_txn #(
    parameter int ADDR_W    = 10,
    parameter int SETUP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        inst,
    input  logic [7:0]        wdata,
    input  logic              ready,
    input  logic [7:0]        rd_data,
    output logic [ADDR_W-1:0] addr_out,
    output logic [7:0]        data_out,
    output logic [1:0]        inst_out,
    output logic              cs_out,
    output logic              done,
    output logic [7:0]        rdata
);
    import rf_pkg::*;

    txn_phase_t        phase_reg, phase_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic              cs_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        data_reg;
    logic [1:0]        inst_reg;
    logic              cs_reg;
    logic [7:0]        rdata_reg;

    always_comb begin
        phase_next = phase_reg;
        cnt_next   = cnt_reg;
        cs_next    = 1'b0;
        done       = 1'b0;
        case (phase_reg)
            TX_IDLE: begin
                if (start) begin
                    phase_next = TX_SETUP;
                    cnt_next   = '0;
                end
            end
            TX_SETUP: begin
                if (cnt_reg == 8'(SETUP_CYC - 1)) begin
                    phase_next = TX_CS;
                    cs_next    = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            TX_CS: begin
                phase_next = TX_BLANK;
                cnt_next   = '0;
            end
            TX_BLANK: begin
                if (cnt_reg == 8'd2) begin
                    phase_next = TX_WAIT;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            TX_WAIT: begin
                // A back-to-back start in the completion cycle keeps the byte period tight
                if (ready) begin
                    done       = 1'b1;
                    phase_next = start ? TX_SETUP : TX_IDLE;
                    cnt_next   = '0;
                end
            end
            default: phase_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg <= TX_IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            inst_reg  <= '0;
            cs_reg    <= 1'b0;
            rdata_reg <= '0;
        end else begin
            phase_reg <= phase_next;
            cnt_reg   <= cnt_next;
            cs_reg    <= cs_next;
            if (start && (phase_reg == TX_IDLE || done)) begin
                addr_reg <= addr;
                data_reg <= wdata;
                inst_reg <= inst;
            end
            if (done) begin
                rdata_reg <= rd_data;
            end
        end
    end

    assign addr_out = addr_reg;
    assign data_out = data_reg;
    assign inst_out = inst_reg;
    assign cs_out   = cs_reg;
    assign rdata    = done ? rd_data : rdata_reg;

endmodule

// File: rtl/rf_rx_engine.sv
// Interrupt-driven RF receive engine: INTSTAT -> length -> frame bytes streamed out.
// Define RF_RX_BBREG_EN to bracket the FIFO drain with BBREG1 RX disable/enable writes.
module rf_rx_engine #(
    parameter int                ADDR_W       = 10,
    parameter logic [ADDR_W-1:0] RX_BASE      = ADDR_W'(rf_pkg::RX_FIFO_BASE),
    parameter logic [ADDR_W-1:0] INTSTAT_ADDR = ADDR_W'(rf_pkg::INTSTAT_ADDR),
    parameter int                RXIF_BIT     = 3,
    parameter int                MAX_FRAME    = 127,
    parameter int                SETUP_CYC    = 2,
    parameter int                GAP_CYC      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_en,
    input  logic              intr,
    input  logic              ready,
    input  logic [7:0]        rd_data,
    output logic [ADDR_W-1:0] addr_out,
    output logic [7:0]        data_out,
    output logic [1:0]        inst,
    output logic              cs_out,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    output logic              rx_last,
    input  logic              rx_ready,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt
);
    import rf_pkg::*;

    rx_state_t         state_reg, state_next;
    logic              intr_reg;
    logic [7:0]        len_reg;
    logic [7:0]        idx_reg;
    logic [15:0]       gap_cnt_reg;
    logic [7:0]        rx_data_reg;
    logic              rx_valid_reg;
    logic              rx_last_reg;
    logic [15:0]       frame_cnt_reg;
    logic [15:0]       drop_cnt_reg;

    logic              txn_start;
    logic [ADDR_W-1:0] txn_addr;
    rf_inst_t          txn_inst;
    logic [7:0]        txn_wdata;
    logic              txn_done;
    logic [7:0]        txn_rdata;

    logic len_ok;
    logic len_load, drop_inc, frame_inc, idx_inc, push_load, pop;

    assign len_ok = (txn_rdata != 8'd0) && (int'(txn_rdata) <= MAX_FRAME);

    always_comb begin
        state_next = state_reg;
        txn_start  = 1'b0;
        txn_addr   = '0;
        txn_inst   = RF_SHORT_RD;
        txn_wdata  = '0;
        len_load   = 1'b0;
        drop_inc   = 1'b0;
        frame_inc  = 1'b0;
        idx_inc    = 1'b0;
        push_load  = 1'b0;
        pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (rx_en && !intr_reg) begin
                    state_next = ST_ISR;
                    txn_start  = 1'b1;
                    txn_addr   = INTSTAT_ADDR;
                    txn_inst   = RF_SHORT_RD;
                end
            end
            ST_ISR: begin
                if (txn_done) begin
                    if (txn_rdata[RXIF_BIT]) begin
                        state_next = ST_LEN;
                        txn_start  = 1'b1;
                        txn_addr   = RX_BASE;
                        txn_inst   = RF_LONG_RD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_LEN: begin
                if (txn_done) begin
                    if (len_ok) begin
                        len_load = 1'b1;
`ifdef RF_RX_BBREG_EN
                        state_next = ST_BB_DIS;
                        txn_start  = 1'b1;
                        txn_addr   = ADDR_W'(BBREG1_ADDR);
                        txn_inst   = RF_SHORT_WR;
                        txn_wdata  = BBREG1_RX_DIS;
`else
                        state_next = ST_DATA;
                        txn_start  = 1'b1;
                        txn_addr   = RX_BASE + ADDR_W'(1);
                        txn_inst   = RF_LONG_RD;
`endif
                    end else begin
                        drop_inc = 1'b1;
`ifdef RF_RX_BBREG_EN
                        state_next = ST_BB_EN;
                        txn_start  = 1'b1;
                        txn_addr   = ADDR_W'(BBREG1_ADDR);
                        txn_inst   = RF_SHORT_WR;
                        txn_wdata  = BBREG1_RX_EN;
`else
                        state_next = ST_GAP;
`endif
                    end
                end
            end
            ST_DATA: begin
                if (txn_done) begin
                    push_load  = 1'b1;
                    state_next = ST_PUSH;
                end
            end
            ST_PUSH: begin
                // Next FIFO read is only launched once the held byte is taken
                if (rx_ready) begin
                    pop = 1'b1;
                    if (rx_last_reg) begin
                        frame_inc = 1'b1;
`ifdef RF_RX_BBREG_EN
                        state_next = ST_BB_EN;
                        txn_start  = 1'b1;
                        txn_addr   = ADDR_W'(BBREG1_ADDR);
                        txn_inst   = RF_SHORT_WR;
                        txn_wdata  = BBREG1_RX_EN;
`else
                        state_next = ST_GAP;
`endif
                    end else begin
                        idx_inc    = 1'b1;
                        state_next = ST_DATA;
                        txn_start  = 1'b1;
                        txn_addr   = RX_BASE + ADDR_W'(idx_reg) + ADDR_W'(2);
                        txn_inst   = RF_LONG_RD;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == 16'(GAP_CYC - 1)) begin
                    state_next = ST_IDLE;
                end
            end
`ifdef RF_RX_BBREG_EN
            ST_BB_DIS: begin
                if (txn_done) begin
                    state_next = ST_DATA;
                    txn_start  = 1'b1;
                    txn_addr   = RX_BASE + ADDR_W'(1);
                    txn_inst   = RF_LONG_RD;
                end
            end
            ST_BB_EN: begin
                if (txn_done) begin
                    state_next = ST_GAP;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            intr_reg      <= 1'b1;
            len_reg       <= '0;
            idx_reg       <= '0;
            gap_cnt_reg   <= '0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            rx_last_reg   <= 1'b0;
            frame_cnt_reg <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            intr_reg    <= intr;
            gap_cnt_reg <= (state_reg == ST_GAP) ? gap_cnt_reg + 16'd1 : 16'd0;
            if (len_load) begin
                len_reg <= txn_rdata;
                idx_reg <= '0;
            end else if (idx_inc) begin
                idx_reg <= idx_reg + 8'd1;
            end
            if (push_load) begin
                rx_data_reg  <= txn_rdata;
                rx_valid_reg <= 1'b1;
                rx_last_reg  <= (idx_reg == len_reg - 8'd1);
            end else if (pop) begin
                rx_valid_reg <= 1'b0;
                rx_last_reg  <= 1'b0;
            end
            if (frame_inc) begin
                frame_cnt_reg <= sat_inc(frame_cnt_reg);
            end
            if (drop_inc) begin
                drop_cnt_reg <= sat_inc(drop_cnt_reg);
            end
        end
    end

    rf_spi_txn #(
        .ADDR_W    (ADDR_W),
        .SETUP_CYC (SETUP_CYC)
    ) u_txn (
        .clk      (clk),
        .rst      (rst),
        .start    (txn_start),
        .addr     (txn_addr),
        .inst     (txn_inst),
        .wdata    (txn_wdata),
        .ready    (ready),
        .rd_data  (rd_data),
        .addr_out (addr_out),
        .data_out (data_out),
        .inst_out (inst),
        .cs_out   (cs_out),
        .done     (txn_done),
        .rdata    (txn_rdata)
    );

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign rx_last   = rx_last_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign frame_cnt = frame_cnt_reg;
    assign drop_cnt  = drop_cnt_reg;

endmodule
